// File: rtl/ring_phase_monitor.sv
// Downstream monitor for a one-hot ring counter: encodes the phase, locks onto clean
// rotation, flags sticky faults after lock and counts completed revolutions.
module ring_phase_monitor #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PH_W     = 2,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned REV_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ring_in,
    input  logic             clr_err,
    output logic [PH_W-1:0]  phase,
    output logic             phase_vld,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_cnt,
    output logic [REV_W-1:0] rev_cnt,
    output logic             rev_tick
);

    localparam int unsigned CntW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(LOCK_CNT - 1);

    typedef enum logic [1:0] {
        StSearch,
        StLocking,
        StLocked,
        StFault
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [CntW-1:0]  good_cnt_q, good_cnt_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             phase_vld_q, phase_vld_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [REV_W-1:0] rev_cnt_q, rev_cnt_d;
    logic             rev_tick_q, rev_tick_d;

    logic             oh, prev_oh, good, wrap;
    logic [WIDTH-1:0] prev_rot;

    function automatic logic [PH_W-1:0] encode(input logic [WIDTH-1:0] x);
        logic [PH_W-1:0] enc;
        enc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x[i]) enc = enc | PH_W'(i);
        end
        return enc;
    endfunction

    always_comb begin
        oh       = $onehot(ring_in);
        prev_oh  = $onehot(prev_q);
        prev_rot = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
        good     = oh && prev_oh && (ring_in == prev_rot);
        wrap     = good && ring_in[0] && prev_q[WIDTH-1];
    end

    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        err_cnt_d   = err_cnt_q;
        rev_cnt_d   = rev_cnt_q;
        rev_tick_d  = 1'b0;
        prev_d      = ring_in;
        phase_vld_d = oh;
        phase_d     = oh ? encode(ring_in) : '0;

        unique case (state_q)
            StSearch: begin
                if (oh) begin
                    state_d    = StLocking;
                    good_cnt_d = '0;
                end
            end
            StLocking: begin
                if (!good) begin
                    state_d = StSearch;
                end else if (good_cnt_q == CntLast) begin
                    state_d = StLocked;
                end else begin
                    good_cnt_d = good_cnt_q + CntW'(1);
                end
            end
            StLocked: begin
                // A faulting sample can never also be a wrap, so no tick on the fault edge.
                if (!good) begin
                    state_d = StFault;
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                end else if (wrap) begin
                    rev_cnt_d  = rev_cnt_q + REV_W'(1);
                    rev_tick_d = 1'b1;
                end
            end
            StFault: begin
                if (clr_err) state_d = StSearch;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StSearch;
            prev_q      <= '0;
            good_cnt_q  <= '0;
            phase_q     <= '0;
            phase_vld_q <= 1'b0;
            err_cnt_q   <= '0;
            rev_cnt_q   <= '0;
            rev_tick_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            good_cnt_q  <= good_cnt_d;
            phase_q     <= phase_d;
            phase_vld_q <= phase_vld_d;
            err_cnt_q   <= err_cnt_d;
            rev_cnt_q   <= rev_cnt_d;
            rev_tick_q  <= rev_tick_d;
        end
    end

    assign phase     = phase_q;
    assign phase_vld = phase_vld_q;
    assign locked    = (state_q == StLocked);
    assign err       = (state_q == StFault);
    assign err_cnt   = err_cnt_q;
    assign rev_cnt   = rev_cnt_q;
    assign rev_tick  = rev_tick_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Bench for ring_phase_monitor: directed scenarios plus random stimulus, checked every
// cycle against a behavioural model; a second instance with REV_W=2 checks counter wrap.
module tb_ring_phase_monitor;

    localparam int LockCnt = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] ring_in = 4'b0000;
    logic       clr_err = 1'b0;

    logic [1:0] phase,  phase2;
    logic       vld,    vld2;
    logic       locked, locked2;
    logic       err,    err2;
    logic [7:0] ecnt,   ecnt2;
    logic [7:0] rev;
    logic [1:0] rev2;
    logic       tick,   tick2;

    ring_phase_monitor #(.WIDTH(4), .PH_W(2), .LOCK_CNT(LockCnt), .REV_W(8)) dut (
        .clk(clk), .rst(rst), .ring_in(ring_in), .clr_err(clr_err),
        .phase(phase), .phase_vld(vld), .locked(locked), .err(err),
        .err_cnt(ecnt), .rev_cnt(rev), .rev_tick(tick)
    );

    ring_phase_monitor #(.WIDTH(4), .PH_W(2), .LOCK_CNT(LockCnt), .REV_W(2)) dut2 (
        .clk(clk), .rst(rst), .ring_in(ring_in), .clr_err(clr_err),
        .phase(phase2), .phase_vld(vld2), .locked(locked2), .err(err2),
        .err_cnt(ecnt2), .rev_cnt(rev2), .rev_tick(tick2)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: mode 0 searching, 1 counting good steps, 2 locked, 3 faulted.
    int m_mode = 0;
    int m_run  = 0;
    int m_prev = 0;
    int e_phase = 0, e_vld = 0, e_err_cnt = 0, e_rev = 0, e_tick = 0;

    int pos = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_run = 0; m_prev = 0;
        e_phase = 0; e_vld = 0; e_err_cnt = 0; e_rev = 0; e_tick = 0;
    endtask

    task automatic model_update(input int v, input bit c);
        bit oh, good, wrap;
        int rot;
        oh   = ($countones(v) == 1);
        rot  = ((m_prev << 1) | (m_prev >> 3)) & 15;
        good = oh && ($countones(m_prev) == 1) && (v == rot);
        wrap = good && (v == 1) && (m_prev == 8);
        e_tick = 0;
        case (m_mode)
            0: if (oh) begin m_mode = 1; m_run = 0; end
            1: begin
                if (good) begin
                    m_run++;
                    if (m_run == LockCnt) m_mode = 2;
                end else m_mode = 0;
            end
            2: begin
                if (!good) begin
                    m_mode = 3;
                    if (e_err_cnt < 255) e_err_cnt++;
                end else if (wrap) begin
                    e_rev++;
                    e_tick = 1;
                end
            end
            default: if (c) m_mode = 0;
        endcase
        e_vld   = oh;
        e_phase = oh ? $clog2(v) : 0;
        m_prev  = v;
    endtask

    function automatic logic [3:0] seq(input int p);
        logic [3:0] s;
        s = 4'b0001 << (p % 4);
        return s;
    endfunction

    task automatic tick_in(input logic [3:0] v, input logic c);
        ring_in = v;
        clr_err = c;
        @(posedge clk);
        if (rst) model_update(int'(v), c);
        #1;
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            tick_in(seq(pos), 1'b0);
            pos++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) tick_in(4'($urandom_range(0, 15)), 1'b0);
        ring_in = 4'b0000;
        rst = 1'b1;
        pos = 0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check("phase",     32'(phase),  32'(e_phase));
            check("phase_vld", 32'(vld),    32'(e_vld));
            check("locked",    32'(locked), 32'(m_mode == 2));
            check("err",       32'(err),    32'(m_mode == 3));
            check("err_cnt",   32'(ecnt),   32'(e_err_cnt));
            check("rev_cnt",   32'(rev),    32'(e_rev % 256));
            check("rev_tick",  32'(tick),   32'(e_tick));
            check("rev_cnt_w2",  32'(rev2),  32'(e_rev % 4));
            check("rev_tick_w2", 32'(tick2), 32'(e_tick));
        end
    end

    initial begin
        // Reset held while input toggles, then a stuck pattern never locks.
        model_reset();
        for (int i = 0; i < 6; i++) tick_in(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        check("rst_locked", 32'(locked), 0);
        check("rst_vld", 32'(vld), 0);
        check("rst_errcnt", 32'(ecnt), 0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) tick_in(4'b0001, 1'b0);
        check("stuck_locked", 32'(locked), 0);
        check("stuck_err", 32'(err), 0);

        // Clean sequence: lock at cycle LOCK_CNT+1, then count revolutions.
        do_reset();
        feed(4);
        check("prelock", 32'(locked), 0);
        check("phase_lit", 32'(phase), 3);
        feed(1);
        check("lock_c5", 32'(locked), 1);
        feed(4);
        check("rev1", 32'(rev), 1);
        check("tick1", 32'(tick), 1);
        feed(8);
        check("rev3", 32'(rev), 3);
        feed(4);
        check("rev4", 32'(rev), 4);
        check("rev_w2_wrap", 32'(rev2), 0);

        // Illegal multi-hot sample while locked.
        tick_in(4'b0110, 1'b0);
        check("fault_vld", 32'(vld), 0);
        check("fault_locked", 32'(locked), 0);
        check("fault_err", 32'(err), 1);
        check("fault_errcnt", 32'(ecnt), 1);
        feed(8);
        check("fault_hold", 32'(err), 1);
        check("rev_frozen", 32'(rev), 4);

        // Clear, relock, then a skipped rotation.
        tick_in(seq(pos), 1'b1);
        pos++;
        check("clr_err", 32'(err), 0);
        check("clr_errcnt", 32'(ecnt), 1);
        feed(4);
        check("relock_early", 32'(locked), 0);
        feed(1);
        check("relock", 32'(locked), 1);
        while (seq(pos) != 4'b0100) feed(1);
        tick_in(4'b1000, 1'b0);
        pos += 2;
        check("skip_errcnt", 32'(ecnt), 2);
        check("skip_err", 32'(err), 1);

        // Asynchronous reset between edges while locked with rev_cnt=2.
        do_reset();
        feed(13);
        check("pre_arst_rev", 32'(rev), 2);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("arst_locked", 32'(locked), 0);
        check("arst_rev", 32'(rev), 0);
        check("arst_phase", 32'(phase), 0);
        check("arst_vld", 32'(vld), 0);
        tick_in(4'b0001, 1'b0);
        rst = 1'b1;
        pos = 1;

        // Randomised run: mostly clean rotation with occasional corruption and clears.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 85) begin
                tick_in(seq(pos), 1'($urandom_range(0, 9) == 0));
                pos++;
            end else if (r < 93) begin
                tick_in(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0));
            end else begin
                pos++;
                tick_in(seq(pos), 1'b0);
                pos++;
            end
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
